// File: rtl/axi_arb_pkg.sv
// Shared types for the AXI read-port arbiter:
// FSM states, requester ids and burst codes.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;

endpackage

// File: rtl/axi_rbeat_monitor.sv
// Beat counter and burst-length checker for the
// R channel; raises a sticky protocol_error flag.
module axi_rbeat_monitor #(
  parameter int len_width = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 ar_hs,
  input  logic [len_width-1:0] arlen,
  input  logic                 r_hs,
  input  logic                 rlast,
  input  logic                 rvalid,
  input  logic                 in_data,
  output logic                 protocol_error
);

  localparam logic [len_width-1:0] ONE = 1;

  logic [len_width-1:0] beat_cnt_q, beat_cnt_d;
  logic [len_width-1:0] exp_len_q, exp_len_d;
  logic                 err_q, err_d;

  // count beats, compare before increment so arlen=255 never wraps early
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    exp_len_d  = exp_len_q;
    err_d      = err_q;
    if (ar_hs) begin
      exp_len_d  = arlen;
      beat_cnt_d = '0;
    end
    if (r_hs) begin
      beat_cnt_d = beat_cnt_q + ONE;
      if (rlast != (beat_cnt_q == exp_len_q))
        err_d = 1'b1;
    end
    if (rvalid && !in_data)
      err_d = 1'b1;
  end

  // counter, length and sticky error registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat_cnt_q <= '0;
      exp_len_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      exp_len_q  <= exp_len_d;
      err_q      <= err_d;
    end
  end

  assign protocol_error = err_q;

endmodule

// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read port
// between the I-cache and D-cache, one burst at a time.
module axi_read_arbiter
  import axi_arb_pkg::*;
#(
  parameter int addr_width = 64,
  parameter int data_width = 64,
  parameter int len_width  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ic_axi_arvalid,
  input  logic [addr_width-1:0] ic_axi_araddr,
  input  logic [len_width-1:0]  ic_axi_arlen,
  input  logic [2:0]            ic_axi_arsize,
  input  logic [1:0]            ic_axi_arburst,
  output logic                  ic_axi_arready,
  output logic                  ic_axi_rvalid,
  output logic [data_width-1:0] ic_axi_rdata,
  output logic                  ic_axi_rlast,
  input  logic                  ic_axi_rready,
  input  logic                  dc_axi_arvalid,
  input  logic [addr_width-1:0] dc_axi_araddr,
  input  logic [len_width-1:0]  dc_axi_arlen,
  input  logic [2:0]            dc_axi_arsize,
  input  logic [1:0]            dc_axi_arburst,
  output logic                  dc_axi_arready,
  output logic                  dc_axi_rvalid,
  output logic [data_width-1:0] dc_axi_rdata,
  output logic                  dc_axi_rlast,
  input  logic                  dc_axi_rready,
  output logic                  m_axi_arvalid,
  output logic [addr_width-1:0] m_axi_araddr,
  output logic [len_width-1:0]  m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  input  logic                  m_axi_arready,
  input  logic                  m_axi_rvalid,
  input  logic [data_width-1:0] m_axi_rdata,
  input  logic                  m_axi_rlast,
  output logic                  m_axi_rready,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  protocol_error
);

  arb_state_e state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       sel_dc;
  logic       ar_v;
  logic       rr;
  logic       ar_hs;
  logic       r_hs;
  logic       in_data;

  assign sel_dc  = grant_q[1];
  assign in_data = (state_q == DATA);

  // next state, round-robin pick and channel muxing
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    last_d         = last_q;
    ar_v           = 1'b0;
    rr             = 1'b0;
    m_axi_arvalid  = 1'b0;
    m_axi_araddr   = '0;
    m_axi_arlen    = '0;
    m_axi_arsize   = '0;
    m_axi_arburst  = '0;
    m_axi_rready   = 1'b0;
    ic_axi_arready = 1'b0;
    dc_axi_arready = 1'b0;
    ic_axi_rvalid  = 1'b0;
    dc_axi_rvalid  = 1'b0;
    ic_axi_rdata   = '0;
    dc_axi_rdata   = '0;
    ic_axi_rlast   = 1'b0;
    dc_axi_rlast   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ic_axi_arvalid && dc_axi_arvalid)
          grant_d = (last_q == REQ_DC) ? 2'b01 : 2'b10;
        else if (ic_axi_arvalid)
          grant_d = 2'b01;
        else if (dc_axi_arvalid)
          grant_d = 2'b10;
        if (ic_axi_arvalid || dc_axi_arvalid)
          state_d = ADDR;
      end
      ADDR: begin
        ar_v           = sel_dc ? dc_axi_arvalid : ic_axi_arvalid;
        m_axi_arvalid  = ar_v;
        m_axi_araddr   = sel_dc ? dc_axi_araddr  : ic_axi_araddr;
        m_axi_arlen    = sel_dc ? dc_axi_arlen   : ic_axi_arlen;
        m_axi_arsize   = sel_dc ? dc_axi_arsize  : ic_axi_arsize;
        m_axi_arburst  = sel_dc ? dc_axi_arburst : ic_axi_arburst;
        ic_axi_arready = grant_q[0] & m_axi_arready;
        dc_axi_arready = grant_q[1] & m_axi_arready;
        if (ar_v && m_axi_arready)
          state_d = DATA;
      end
      DATA: begin
        rr            = sel_dc ? dc_axi_rready : ic_axi_rready;
        m_axi_rready  = rr;
        ic_axi_rvalid = grant_q[0] & m_axi_rvalid;
        dc_axi_rvalid = grant_q[1] & m_axi_rvalid;
        ic_axi_rdata  = m_axi_rdata;
        dc_axi_rdata  = m_axi_rdata;
        ic_axi_rlast  = m_axi_rlast;
        dc_axi_rlast  = m_axi_rlast;
        if (m_axi_rvalid && rr && m_axi_rlast) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = sel_dc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state, owner and round-robin pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 2'b00;
      last_q  <= REQ_DC;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rvalid & m_axi_rready;
  assign grant = grant_q;
  assign busy  = (state_q != IDLE);

  axi_rbeat_monitor #(
    .len_width(len_width)
  ) u_mon (
    .clock          (clock),
    .reset          (reset),
    .ar_hs          (ar_hs),
    .arlen          (m_axi_arlen),
    .r_hs           (r_hs),
    .rlast          (m_axi_rlast),
    .rvalid         (m_axi_rvalid),
    .in_data        (in_data),
    .protocol_error (protocol_error)
  );

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: requester drivers,
// memory model and beat scoreboard.
module tb_axi_read_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 8;

  logic          clock, reset;
  logic          ic_axi_arvalid, ic_axi_arready;
  logic [AW-1:0] ic_axi_araddr;
  logic [LW-1:0] ic_axi_arlen;
  logic [2:0]    ic_axi_arsize;
  logic [1:0]    ic_axi_arburst;
  logic          ic_axi_rvalid, ic_axi_rlast, ic_axi_rready;
  logic [DW-1:0] ic_axi_rdata;
  logic          dc_axi_arvalid, dc_axi_arready;
  logic [AW-1:0] dc_axi_araddr;
  logic [LW-1:0] dc_axi_arlen;
  logic [2:0]    dc_axi_arsize;
  logic [1:0]    dc_axi_arburst;
  logic          dc_axi_rvalid, dc_axi_rlast, dc_axi_rready;
  logic [DW-1:0] dc_axi_rdata;
  logic          m_axi_arvalid, m_axi_arready;
  logic [AW-1:0] m_axi_araddr;
  logic [LW-1:0] m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_rvalid, m_axi_rlast, m_axi_rready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    grant;
  logic          busy, protocol_error;

  axi_read_arbiter dut (
    .clock(clock), .reset(reset),
    .ic_axi_arvalid(ic_axi_arvalid), .ic_axi_araddr(ic_axi_araddr),
    .ic_axi_arlen(ic_axi_arlen), .ic_axi_arsize(ic_axi_arsize),
    .ic_axi_arburst(ic_axi_arburst), .ic_axi_arready(ic_axi_arready),
    .ic_axi_rvalid(ic_axi_rvalid), .ic_axi_rdata(ic_axi_rdata),
    .ic_axi_rlast(ic_axi_rlast), .ic_axi_rready(ic_axi_rready),
    .dc_axi_arvalid(dc_axi_arvalid), .dc_axi_araddr(dc_axi_araddr),
    .dc_axi_arlen(dc_axi_arlen), .dc_axi_arsize(dc_axi_arsize),
    .dc_axi_arburst(dc_axi_arburst), .dc_axi_arready(dc_axi_arready),
    .dc_axi_rvalid(dc_axi_rvalid), .dc_axi_rdata(dc_axi_rdata),
    .dc_axi_rlast(dc_axi_rlast), .dc_axi_rready(dc_axi_rready),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_araddr(m_axi_araddr),
    .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rdata(m_axi_rdata),
    .m_axi_rlast(m_axi_rlast), .m_axi_rready(m_axi_rready),
    .grant(grant), .busy(busy), .protocol_error(protocol_error)
  );

  typedef struct {
    logic        owner;
    logic [63:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        req;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
    logic [1:0]  g;
  } vec_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          last_hs_cyc = -100;
  int          ar_stall = 0;
  int          err_beat = -1;
  int          sl_beat = 0;
  logic [63:0] rq_addr[2];
  logic [7:0]  rq_len[2];
  logic [1:0]  rq_burst[2];
  int          rq_cnt[2];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit hit");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] bdata(input logic [63:0] a, input int i);
    logic [7:0] b;
    b = 8'(i);
    return {a[55:0], b};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", nm);
  endtask

  task automatic push_burst(input logic who, input logic [63:0] a,
                            input int nb, input int li);
    beat_t e;
    for (int i = 0; i < nb; i++) begin
      e.owner = who;
      e.data  = bdata(a, i);
      e.last  = (i == li);
      exp_q.push_back(e);
    end
  endtask

  task automatic sb_pop(input logic who, input logic [63:0] d,
                        input logic l);
    beat_t e;
    chk("sb_nonempty", 64'(exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    chk("beat_owner", 64'(who), 64'(e.owner));
    chk("beat_data", d, e.data);
    chk("beat_last", 64'(l), 64'(e.last));
    if (l) last_hs_cyc = cyc;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic who, input logic [63:0] a,
                       input logic [7:0] l, input logic [1:0] b);
    rq_addr[who]  = a;
    rq_len[who]   = l;
    rq_burst[who] = b;
    rq_cnt[who]++;
  endtask

  task automatic wait_ar(output int n);
    logic prev;
    logic hit;
    prev = m_axi_arvalid;
    hit  = 1'b0;
    n    = 0;
    while (!hit && n < 700) begin
      @(negedge clock);
      n++;
      hit  = m_axi_arvalid && !prev;
      prev = m_axi_arvalid;
    end
    if (!hit) timeout("wait_arvalid");
  endtask

  task automatic wait_idle(output int c);
    int k;
    k = 0;
    @(negedge clock);
    while (busy && k < 700) begin
      @(negedge clock);
      k++;
    end
    if (busy) timeout("wait_idle");
    c = cyc;
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
  endtask

  // I-cache requester: holds arvalid until its AR handshake
  initial begin : drv_ic
    logic hs;
    int   done;
    done = 0;
    ic_axi_arvalid = 1'b0;
    ic_axi_araddr  = '0;
    ic_axi_arlen   = '0;
    ic_axi_arsize  = '0;
    ic_axi_arburst = '0;
    forever begin
      @(negedge clock);
      hs = ic_axi_arvalid && ic_axi_arready;
      @(posedge clock);
      #2;
      if (hs || reset) ic_axi_arvalid = 1'b0;
      if (!ic_axi_arvalid && done != rq_cnt[0]) begin
        ic_axi_arvalid = 1'b1;
        ic_axi_araddr  = rq_addr[0];
        ic_axi_arlen   = rq_len[0];
        ic_axi_arsize  = 3'd3;
        ic_axi_arburst = rq_burst[0];
        done++;
      end
    end
  end

  // D-cache requester: same behaviour on the dc_ side
  initial begin : drv_dc
    logic hs;
    int   done;
    done = 0;
    dc_axi_arvalid = 1'b0;
    dc_axi_araddr  = '0;
    dc_axi_arlen   = '0;
    dc_axi_arsize  = '0;
    dc_axi_arburst = '0;
    forever begin
      @(negedge clock);
      hs = dc_axi_arvalid && dc_axi_arready;
      @(posedge clock);
      #2;
      if (hs || reset) dc_axi_arvalid = 1'b0;
      if (!dc_axi_arvalid && done != rq_cnt[1]) begin
        dc_axi_arvalid = 1'b1;
        dc_axi_araddr  = rq_addr[1];
        dc_axi_arlen   = rq_len[1];
        dc_axi_arsize  = 3'd3;
        dc_axi_arburst = rq_burst[1];
        done++;
      end
    end
  end

  // memory model: optional AR stall, beats tagged with address
  initial begin : slave
    logic        ahs, rhs, sl_busy;
    logic [63:0] a_addr, sl_addr;
    logic [7:0]  a_len;
    int          sl_last, stall_cnt;
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rlast   = 1'b0;
    sl_busy = 1'b0;
    sl_addr = '0;
    sl_last = 0;
    stall_cnt = 0;
    forever begin
      @(negedge clock);
      ahs    = m_axi_arvalid && m_axi_arready;
      rhs    = m_axi_rvalid && m_axi_rready;
      a_addr = m_axi_araddr;
      a_len  = m_axi_arlen;
      @(posedge clock);
      #1;
      if (reset) begin
        sl_busy = 1'b0;
        sl_beat = 0;
        stall_cnt = 0;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rlast   = 1'b0;
        m_axi_rdata   = '0;
      end else if (!sl_busy) begin
        if (ahs) begin
          sl_busy   = 1'b1;
          sl_addr   = a_addr;
          sl_last   = (err_beat >= 0) ? err_beat : int'(a_len);
          sl_beat   = 0;
          stall_cnt = 0;
          m_axi_arready = 1'b0;
          m_axi_rvalid  = 1'b1;
          m_axi_rdata   = bdata(sl_addr, 0);
          m_axi_rlast   = (sl_last == 0);
        end else if (m_axi_arvalid) begin
          if (stall_cnt >= ar_stall) m_axi_arready = 1'b1;
          else stall_cnt++;
        end else begin
          m_axi_arready = 1'b0;
        end
      end else if (rhs) begin
        if (m_axi_rlast) begin
          sl_busy      = 1'b0;
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rdata  = '0;
        end else begin
          sl_beat++;
          m_axi_rdata = bdata(sl_addr, sl_beat);
          m_axi_rlast = (sl_beat == sl_last);
        end
      end
    end
  end

  // scoreboard and gating checks, sampled mid-cycle
  initial begin : mon
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("gate_ic", 64'({ic_axi_arready, ic_axi_rvalid} & {2{~grant[0]}}), 0);
        chk("gate_dc", 64'({dc_axi_arready, dc_axi_rvalid} & {2{~grant[1]}}), 0);
        chk("gate_idle", busy ? 64'd0 : 64'({m_axi_arvalid, m_axi_rready, grant}), 0);
        if (ic_axi_rvalid && ic_axi_rready)
          sb_pop(1'b0, ic_axi_rdata, ic_axi_rlast);
        if (dc_axi_rvalid && dc_axi_rready)
          sb_pop(1'b1, dc_axi_rdata, dc_axi_rlast);
      end
    end
  end

  initial begin : main
    vec_t        vecs[4];
    logic [63:0] a0, a1;
    int          n, c, k;

    vecs[0] = '{1'b0, 64'h1000, 8'd7,   2'b10, 2'b01};
    vecs[1] = '{1'b1, 64'h2000, 8'd0,   2'b01, 2'b10};
    vecs[2] = '{1'b0, 64'h3000, 8'd255, 2'b01, 2'b01};
    vecs[3] = '{1'b1, 64'h4000, 8'd3,   2'b10, 2'b10};

    rq_cnt[0] = 0;
    rq_cnt[1] = 0;
    ic_axi_rready = 1'b1;
    dc_axi_rready = 1'b1;
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst_flags", 64'({grant, busy, protocol_error, m_axi_arvalid,
        m_axi_rready, ic_axi_arready, ic_axi_rvalid, ic_axi_rlast,
        dc_axi_arready, dc_axi_rvalid, dc_axi_rlast}), 0);
    chk("rst_maddr", m_axi_araddr, 0);
    chk("rst_rdata", ic_axi_rdata | dc_axi_rdata, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // single-requester bursts, including 1-beat and 256-beat
    foreach (vecs[i]) begin
      push_burst(vecs[i].req, vecs[i].addr, int'(vecs[i].len) + 1,
                 int'(vecs[i].len));
      step();
      issue(vecs[i].req, vecs[i].addr, vecs[i].len, vecs[i].burst);
      wait_ar(n);
      chk("ar_latency", 64'(n), 2);
      chk("tbl_grant", 64'(grant), 64'(vecs[i].g));
      chk("tbl_araddr", m_axi_araddr, vecs[i].addr);
      chk("tbl_arlen", 64'(m_axi_arlen), 64'(vecs[i].len));
      chk("tbl_arburst", 64'(m_axi_arburst), 64'(vecs[i].burst));
      chk("tbl_arsize", 64'(m_axi_arsize), 3);
      wait_idle(c);
      chk("busy_fall", 64'(c - last_hs_cyc), 1);
      chk("tbl_drained", 64'(exp_q.size()), 0);
      chk("perr_clean", 64'(protocol_error), 0);
    end

    // ties after reset: I-cache first, then D-cache, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      a0 = 64'h5000 + 64'(r);
      a1 = 64'h6000 + 64'(r);
      push_burst(1'b0, a0, 2, 1);
      push_burst(1'b1, a1, 2, 1);
      step();
      issue(1'b0, a0, 8'd1, 2'b01);
      issue(1'b1, a1, 8'd1, 2'b01);
      wait_ar(n);
      chk("tie_grant_1st", 64'(grant), 2'b01);
      chk("tie_addr_1st", m_axi_araddr, a0);
      wait_ar(n);
      chk("tie_grant_2nd", 64'(grant), 2'b10);
      chk("tie_addr_2nd", m_axi_araddr, a1);
      wait_idle(c);
      chk("tie_drained", 64'(exp_q.size()), 0);
    end

    // D-cache arrives mid I-cache burst
    push_burst(1'b0, 64'h7000, 8, 7);
    step();
    issue(1'b0, 64'h7000, 8'd7, 2'b01);
    wait_ar(n);
    repeat (3) @(posedge clock);
    #1;
    push_burst(1'b1, 64'h8000, 4, 3);
    issue(1'b1, 64'h8000, 8'd3, 2'b01);
    wait_ar(n);
    chk("late_grant", 64'(grant), 2'b10);
    chk("late_gap", 64'(cyc - last_hs_cyc), 2);
    chk("late_addr", m_axi_araddr, 64'h8000);
    wait_idle(c);
    chk("late_drained", 64'(exp_q.size()), 0);

    // AR backpressure, then rready toggling every cycle
    ar_stall = 5;
    push_burst(1'b0, 64'h9000, 8, 7);
    step();
    issue(1'b0, 64'h9000, 8'd7, 2'b01);
    wait_ar(n);
    for (int i = 0; i < 4; i++) begin
      chk("bp_addr", m_axi_araddr, 64'h9000);
      chk("bp_hold", 64'({m_axi_arvalid, busy, m_axi_rready,
          ic_axi_arready}), 4'b1100);
      @(negedge clock);
    end
    k = 0;
    while (busy && k < 200) begin
      step();
      ic_axi_rready = ~ic_axi_rready;
      @(negedge clock);
      if (busy && !m_axi_arvalid)
        chk("rready_mirror", 64'(m_axi_rready), 64'(ic_axi_rready));
      k++;
    end
    if (busy) timeout("bp_burst");
    ic_axi_rready = 1'b1;
    ar_stall = 0;
    chk("bp_drained", 64'(exp_q.size()), 0);
    chk("bp_perr", 64'(protocol_error), 0);

    // early rlast flags an error that survives clean bursts
    err_beat = 3;
    push_burst(1'b0, 64'hA000, 4, 3);
    step();
    issue(1'b0, 64'hA000, 8'd7, 2'b01);
    wait_ar(n);
    wait_idle(c);
    err_beat = -1;
    chk("perr_set", 64'(protocol_error), 1);
    chk("err_drained", 64'(exp_q.size()), 0);
    push_burst(1'b1, 64'hB000, 2, 1);
    step();
    issue(1'b1, 64'hB000, 8'd1, 2'b01);
    wait_ar(n);
    wait_idle(c);
    chk("perr_sticky", 64'(protocol_error), 1);

    // reset in the middle of a burst
    push_burst(1'b0, 64'hC000, 8, 7);
    step();
    issue(1'b0, 64'hC000, 8'd7, 2'b01);
    wait_ar(n);
    k = 0;
    while (sl_beat < 3 && k < 50) begin
      @(negedge clock);
      k++;
    end
    if (sl_beat < 3) timeout("mid_burst");
    step();
    reset = 1'b1;
    #1;
    chk("mid_rst_flags", 64'({grant, busy, protocol_error, m_axi_arvalid,
        m_axi_rready, ic_axi_rvalid, ic_axi_rlast, dc_axi_rvalid}), 0);
    chk("mid_rst_rdata", ic_axi_rdata, 0);
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    push_burst(1'b0, 64'hD000, 4, 3);
    step();
    issue(1'b0, 64'hD000, 8'd3, 2'b01);
    wait_ar(n);
    chk("post_rst_grant", 64'(grant), 2'b01);
    chk("post_rst_addr", m_axi_araddr, 64'hD000);
    wait_idle(c);
    chk("post_rst_drained", 64'(exp_q.size()), 0);
    chk("post_rst_perr", 64'(protocol_error), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
